gcl_multichannel: RTL and testbench

Parametrised multi-channel linear congruential noise source and the next-generation GCL. Each channel runs its own state recurrence, s ← (MULT·s + INC) mod 2^STATE_WIDTH. Each channel delivers signed noise samples with a programmable attenuation, in either uniform or approximately-Gaussian mode (an Irwin-Hall sum of 4). It feeds the lock-in data-source path through a valid/ready handshake, and the generator never drops or skips samples under backpressure.

---
 rtl/gcl_pkg.sv | 21 ++
 rtl/gcl_multichannel_channel.sv | 67 ++++++
 rtl/gcl_multichannel.sv | 106 ++++++++++
 tb/tb_gcl_multichannel.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcl_pkg.sv
// Shared constants and helpers for the multi-channel LCG noise source.
package gcl_pkg;

  localparam logic [63:0] GOLDEN       = 64'h0000_0000_9E37_79B9;
  localparam logic        MODE_UNIFORM = 1'b0;
  localparam logic        MODE_GAUSS   = 1'b1;

  // One LCG step at 64 bits; callers truncate to their state width (mod 2^W is preserved).
  function automatic logic [63:0] lcg_next(input logic [63:0] s,
                                           input logic [63:0] mult,
                                           input logic [63:0] inc);
    return s * mult + inc;
  endfunction

  // Per-channel seed: base XOR (k * GOLDEN), truncated by the caller.
  function automatic logic [63:0] chan_seed(input logic [63:0] base,
                                            input int unsigned k);
    return base ^ (64'(k) * GOLDEN);
  endfunction

endpackage

// File: rtl/gcl_multichannel_channel.sv
// One noise channel: LCG state, sample extraction and Irwin-Hall accumulator.
module gcl_channel
  import gcl_pkg::*;
#(
  parameter int unsigned       STATE_WIDTH = 32,
  parameter int unsigned       OUT_WIDTH   = 16,
  parameter int unsigned       CH          = 0,
  parameter longint unsigned   MULT        = 69069,
  parameter longint unsigned   INC         = 1,
  parameter longint unsigned   RESET_SEED  = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Load,
  input  logic [STATE_WIDTH-1:0] i_Base,
  input  logic                   i_Adv,
  input  logic [1:0]             i_Phase,
  input  logic                   i_Mode,
  input  logic [4:0]             i_Sh,
  output logic [OUT_WIDTH-1:0]   o_Word_c
);

  localparam int unsigned AW = OUT_WIDTH + 2;

  logic [STATE_WIDTH-1:0] state_q, state_d, state_step, seed_load, seed_rst;
  logic signed [AW-1:0]   acc_q, acc_d, sum;
  logic signed [OUT_WIDTH-1:0] u, avg;

  assign state_step = STATE_WIDTH'(lcg_next(64'(state_q), 64'(MULT), 64'(INC)));
  assign seed_load  = STATE_WIDTH'(chan_seed(64'(i_Base), CH));
  assign seed_rst   = STATE_WIDTH'(chan_seed(64'(RESET_SEED), CH));

  // Sample is taken from the post-step state.
  assign u   = state_step[STATE_WIDTH-1 -: OUT_WIDTH];
  assign sum = acc_q + AW'(u);
  assign avg = OUT_WIDTH'(sum >>> 2);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    if (i_Load) begin
      state_d = seed_load;
      acc_d   = '0;
    end else if (i_Adv) begin
      state_d = state_step;
      if (i_Mode == MODE_GAUSS) begin
        case (i_Phase)
          2'd0:    acc_d = AW'(u);
          2'd3:    acc_d = '0;
          default: acc_d = sum;
        endcase
      end
    end
    o_Word_c = (i_Mode == MODE_GAUSS) ? OUT_WIDTH'(avg >>> i_Sh) : OUT_WIDTH'(u >>> i_Sh);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= seed_rst;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/gcl_multichannel.sv
// Multi-channel LCG noise source with uniform / Gaussian modes and a
// lossless valid/ready output stage.
module gcl_multichannel
  import gcl_pkg::*;
#(
  parameter int unsigned     STATE_WIDTH = 32,
  parameter int unsigned     OUT_WIDTH   = 16,
  parameter int unsigned     N_CH        = 4,
  parameter longint unsigned MULT        = 69069,
  parameter longint unsigned INC         = 1,
  parameter longint unsigned RESET_SEED  = 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic                      i_Seed_load,
  input  logic [STATE_WIDTH-1:0]    i_Seed,
  input  logic                      i_Mode,
  input  logic [4:0]                i_Shift,
  input  logic                      i_Ready,
  output logic [N_CH*OUT_WIDTH-1:0] o_Data,
  output logic                      o_Data_valid
);

  localparam int unsigned DW = N_CH * OUT_WIDTH;

  logic [1:0]    phase_q, phase_d;
  logic          mode_q, mode_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] word_c;
  logic          adv, mode_eff, capture;
  logic [4:0]    sh;

  assign adv = i_Enable & ~i_Seed_load & (~valid_q | i_Ready);
  // At a sum boundary the incoming mode applies immediately; mid-sum the latched one holds.
  assign mode_eff = (phase_q == 2'd0) ? i_Mode : mode_q;
  assign sh = (i_Shift > 5'(OUT_WIDTH - 1)) ? 5'(OUT_WIDTH - 1) : i_Shift;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    gcl_channel #(
      .STATE_WIDTH (STATE_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .CH          (k),
      .MULT        (MULT),
      .INC         (INC),
      .RESET_SEED  (RESET_SEED)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Load   (i_Seed_load),
      .i_Base   (i_Seed),
      .i_Adv    (adv),
      .i_Phase  (phase_q),
      .i_Mode   (mode_eff),
      .i_Sh     (sh),
      .o_Word_c (word_c[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  always_comb begin
    phase_d = phase_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    data_d  = data_q;
    capture = 1'b0;
    if (i_Seed_load) begin
      phase_d = 2'd0;
      valid_d = 1'b0;
    end else begin
      if (adv) begin
        if (phase_q == 2'd0) mode_d = i_Mode;
        if (mode_eff == MODE_GAUSS) begin
          phase_d = phase_q + 2'd1;
          capture = (phase_q == 2'd3);
        end else begin
          capture = 1'b1;
        end
      end
      if (capture) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else if (valid_q & i_Ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      phase_q <= 2'd0;
      mode_q  <= MODE_UNIFORM;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_Data       = data_q;
  assign o_Data_valid = valid_q;

endmodule

// File: tb/tb_gcl_multichannel.sv
// Directed, table-driven bench for gcl_multichannel with a small LCG reference model.
module tb_gcl_multichannel;

  localparam int unsigned SW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, en, load, mode, ready;
  logic [SW-1:0]  seed;
  logic [4:0]     shift;
  logic [NC*OW-1:0] data;
  logic           valid;

  int checks = 0;
  int errors = 0;

  gcl_multichannel #(
    .STATE_WIDTH (SW), .OUT_WIDTH (OW), .N_CH (NC),
    .MULT (69069), .INC (1), .RESET_SEED (1)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Enable     (en),
    .i_Seed_load  (load),
    .i_Seed       (seed),
    .i_Mode       (mode),
    .i_Shift      (shift),
    .i_Ready      (ready),
    .o_Data       (data),
    .o_Data_valid (valid)
  );

  typedef struct {
    logic        en;
    logic        load;
    logic [31:0] seed;
    logic        mode;
    logic [4:0]  shift;
    logic        ready;
    logic        adv;
    logic        exp_valid;
    logic        hand;
    logic [15:0] exp_d0;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] ms[NC];
  int          gsum[NC];
  int          gcnt;
  logic [15:0] mw[NC];

  function automatic vec_t mk(input logic e, input logic l, input logic [31:0] s,
                              input logic m, input logic [4:0] sh, input logic r,
                              input logic a, input logic ev, input logic h,
                              input logic [15:0] d0);
    vec_t v;
    v.en = e; v.load = l; v.seed = s; v.mode = m; v.shift = sh; v.ready = r;
    v.adv = a; v.exp_valid = ev; v.hand = h; v.exp_d0 = d0;
    return v;
  endfunction

  function automatic logic [31:0] step32(input logic [31:0] s);
    return s * 32'd69069 + 32'd1;
  endfunction

  task automatic model_seed(input logic [31:0] base);
    for (int k = 0; k < NC; k++) begin
      ms[k]   = base ^ (32'(k) * 32'h9E37_79B9);
      gsum[k] = 0;
    end
    gcnt = 0;
  endtask

  task automatic model_adv(input logic m, input logic [4:0] sh_in);
    int s;
    int u;
    s = (sh_in > 5'd15) ? 15 : int'(sh_in);
    for (int k = 0; k < NC; k++) begin
      ms[k] = step32(ms[k]);
      u = $signed(ms[k][31:16]);
      if (!m) mw[k] = 16'(u >>> s);
      else    gsum[k] = gsum[k] + u;
    end
    if (m) begin
      gcnt++;
      if (gcnt == 4) begin
        for (int k = 0; k < NC; k++) begin
          mw[k]   = 16'((gsum[k] >>> 2) >>> s);
          gsum[k] = 0;
        end
        gcnt = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NC; k++)
      chk($sformatf("%s_ch%0d", tag, k), 64'(data[k*OW +: OW]), 64'(mw[k]));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic l, input logic [31:0] s,
                       input logic m, input logic [4:0] sh, input logic r);
    en = e; load = l; seed = s; mode = m; shift = sh; ready = r;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 1'b0);

    // Uniform run with a 5-cycle stall, then enable-low hold.
    vecs.push_back(mk(1, 1, 32'd0, 0, 5'd0, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 1, 16'h0000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 0, 0, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 1, 16'h0001));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 1, 16'h1C59));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 1, 16'hC359));
    vecs.push_back(mk(0, 0, 32'd0, 0, 5'd0, 0, 0, 1, 1, 16'hC359));
    vecs.push_back(mk(0, 0, 32'd0, 0, 5'd0, 1, 0, 0, 0, 16'h0000));
    // Shift clamp: 20 acts as 15.
    vecs.push_back(mk(1, 1, 32'd0, 0, 5'd20, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd20, 1, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd20, 1, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd20, 1, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd20, 1, 1, 1, 1, 16'hFFFF));
    // Shift 4.
    vecs.push_back(mk(1, 1, 32'd0, 0, 5'd4, 1, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd4, 1, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd4, 1, 1, 1, 1, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd4, 1, 1, 1, 1, 16'h01C5));
    // Gaussian: one word per four steps.
    vecs.push_back(mk(1, 1, 32'd0, 1, 5'd0, 1, 0, 0, 0, 16'h0000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 32'd0, 1, 5'd0, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 1, 5'd0, 1, 1, 1, 1, 16'hF7EC));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 32'd0, 1, 5'd0, 1, 1, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 1, 5'd0, 1, 1, 1, 0, 16'h0000));
    // Seed load discards a pending word held under backpressure.
    vecs.push_back(mk(1, 1, 32'h1234_5678, 0, 5'd0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 0, 16'h0000));
    vecs.push_back(mk(1, 0, 32'd0, 0, 5'd0, 1, 1, 1, 0, 16'h0000));

    cyc();
    cyc();
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_data", 64'(data), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.en, v.load, v.seed, v.mode, v.shift, v.ready);
      if (v.load)     model_seed(v.seed);
      else if (v.adv) model_adv(v.mode, v.shift);
      cyc();
      chk($sformatf("row%0d_valid", i), 64'(valid), 64'(v.exp_valid));
      if (v.exp_valid) check_all($sformatf("row%0d", i));
      if (v.hand) chk($sformatf("row%0d_ch0_hand", i), 64'(data[OW-1:0]), 64'(v.exp_d0));
    end

    // Mode toggled to uniform at phase 2 only applies after the current sum.
    drive(1, 1, 32'd0, 1, 5'd0, 1);
    model_seed(32'd0);
    cyc();
    drive(1, 0, 32'd0, 1, 5'd0, 1);
    for (int i = 0; i < 2; i++) begin
      model_adv(1'b1, 5'd0);
      cyc();
    end
    mode = 1'b0;
    model_adv(1'b1, 5'd0);
    cyc();
    chk("toggle_ph3_valid", 64'(valid), 64'd0);
    model_adv(1'b1, 5'd0);
    cyc();
    chk("toggle_sum_valid", 64'(valid), 64'd1);
    chk("toggle_sum_ch0", 64'(data[OW-1:0]), 64'h0000_0000_0000_F7EC);
    check_all("toggle_sum");
    for (int i = 0; i < 2; i++) begin
      model_adv(1'b0, 5'd0);
      cyc();
      chk($sformatf("toggle_uni%0d_valid", i), 64'(valid), 64'd1);
      check_all($sformatf("toggle_uni%0d", i));
    end

    // Reset while a Gaussian word is pending restarts from RESET_SEED.
    drive(1, 1, 32'd0, 1, 5'd0, 1);
    cyc();
    drive(1, 0, 32'd0, 1, 5'd0, 1);
    for (int i = 0; i < 4; i++) cyc();
    chk("prerst_valid", 64'(valid), 64'd1);
    ready = 1'b0;
    rst   = 1'b1;
    cyc();
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_data", 64'(data), 64'd0);
    rst   = 1'b0;
    mode  = 1'b0;
    ready = 1'b1;
    model_seed(32'd1);
    model_adv(1'b0, 5'd0);
    cyc();
    chk("postrst_valid", 64'(valid), 64'd1);
    chk("postrst_ch0", 64'(data[OW-1:0]), 64'h0000_0000_0000_0001);
    check_all("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
